// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate engine: streams activations against a combinational weight
// memory, then adds the bias, applies ReLU and saturates to the output format.
module neuron_mac #(
   parameter int numWeights   = 16,
   parameter int addressWidth = 4,
   parameter int dataWidth    = 16,
   parameter int fracBits     = 8,
   parameter int accWidth     = 40
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    inValid,
   input  logic [dataWidth-1:0]    inData,
   output logic                    inReady,
   input  logic [dataWidth-1:0]    bias,
   output logic                    weightReadEn,
   output logic [addressWidth-1:0] weightAddr,
   input  logic [dataWidth-1:0]    weightData,
   output logic                    outValid,
   output logic [dataWidth-1:0]    outData,
   input  logic                    outReady,
   output logic                    busy
);

   typedef enum logic [1:0] {ACC, BIAS, ACT, OUT} state_e;

   localparam logic [addressWidth-1:0] LastIdx = addressWidth'(numWeights - 1);
   localparam logic signed [accWidth-1:0] MaxOut =
      {{(accWidth-dataWidth+1){1'b0}}, {(dataWidth-1){1'b1}}};

   state_e                       state_q, state_d;
   logic [addressWidth-1:0]      idx_q, idx_d;
   logic signed [accWidth-1:0]   acc_q, acc_d;
   logic                         outValid_q, outValid_d;
   logic [dataWidth-1:0]         outData_q, outData_d;

   logic signed [2*dataWidth-1:0] product;
   logic signed [accWidth-1:0]    productExt;
   logic signed [accWidth-1:0]    biasExt;
   logic signed [accWidth-1:0]    shifted;
   logic [dataWidth-1:0]          saturated;

   // Full-precision signed product, sign-extended into the accumulator width.
   assign product    = $signed(inData) * $signed(weightData);
   assign productExt = {{(accWidth-2*dataWidth){product[2*dataWidth-1]}}, product};
   assign biasExt    = {{(accWidth-dataWidth){bias[dataWidth-1]}}, bias} <<< fracBits;
   assign shifted    = acc_q >>> fracBits;

   always_comb begin
      saturated = shifted[dataWidth-1:0];
      if (shifted < 0) begin
         saturated = '0;
      end else if (shifted > MaxOut) begin
         saturated = MaxOut[dataWidth-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ACC;
         idx_q      <= '0;
         acc_q      <= '0;
         outValid_q <= 1'b0;
         outData_q  <= '0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         acc_q      <= acc_d;
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      outValid_d = outValid_q;
      outData_d  = outData_q;
      unique case (state_q)
         ACC: begin
            if (inValid) begin
               acc_d = acc_q + productExt;
               if (idx_q == LastIdx) begin
                  idx_d   = '0;
                  state_d = BIAS;
               end else begin
                  idx_d = idx_q + addressWidth'(1);
               end
            end
         end
         BIAS: begin
            acc_d   = acc_q + biasExt;
            state_d = ACT;
         end
         ACT: begin
            outData_d  = saturated;
            outValid_d = 1'b1;
            state_d    = OUT;
         end
         OUT: begin
            // Clearing the accumulator here leaves ACC empty for the next evaluation.
            if (outReady) begin
               outValid_d = 1'b0;
               acc_d      = '0;
               state_d    = ACC;
            end
         end
         default: state_d = ACC;
      endcase
   end

   always_comb begin
      inReady      = (state_q == ACC);
      weightReadEn = (state_q == ACC);
      weightAddr   = idx_q;
      outValid     = outValid_q;
      outData      = outData_q;
      busy         = !((state_q == ACC) && (idx_q == '0) && (acc_q == '0));
   end

endmodule

// File: tb/tb_neuron_mac.sv
// Randomised and directed bench for neuron_mac; a per-cycle compare against an
// arithmetic model of the neuron plus literal expectations for the hand-worked cases.
module tb_neuron_mac;

   localparam int NW = 4;
   localparam int AW = 2;
   localparam int DW = 16;
   localparam int FB = 8;

   logic          clk;
   logic          reset;
   logic          inValid;
   logic [DW-1:0] inData;
   logic          inReady;
   logic [DW-1:0] bias;
   logic          weightReadEn;
   logic [AW-1:0] weightAddr;
   logic [DW-1:0] weightData;
   logic          outValid;
   logic [DW-1:0] outData;
   logic          outReady;
   logic          busy;

   logic [DW-1:0] wmem [NW];
   logic [DW-1:0] xs   [NW];

   int total = 0;
   int bad   = 0;

   neuron_mac #(
      .numWeights(NW), .addressWidth(AW), .dataWidth(DW), .fracBits(FB), .accWidth(40)
   ) dut (
      .clk(clk), .reset(reset), .inValid(inValid), .inData(inData), .inReady(inReady),
      .bias(bias), .weightReadEn(weightReadEn), .weightAddr(weightAddr),
      .weightData(weightData), .outValid(outValid), .outData(outData),
      .outReady(outReady), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational-read weight memory
   assign weightData = wmem[weightAddr];

   task automatic cmp(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic longint sx(input logic [DW-1:0] v);
      return longint'($signed(v));
   endfunction

   // Neuron result straight from the arithmetic: floor((sum + bias*2^FB) / 2^FB), ReLU, clamp.
   function automatic logic [DW-1:0] neuronResult(input longint sum, input longint b);
      longint t;
      longint r;
      t = sum + b * (longint'(1) << FB);
      r = t >>> FB;
      if (r < 0) r = 0;
      if (r > 32767) r = 32767;
      return r[DW-1:0];
   endfunction

   // Model: count of accepted inputs, running sum of products, cycles until result appears.
   int            mCount;
   longint        mSum;
   int            mDelay;
   bit            mOutValid;
   logic [DW-1:0] mOutData;
   longint        mBias;
   bit            modelLive = 1'b0;
   bit            expAccept;

   task automatic modelStep();
      if (reset) begin
         mCount    = 0;
         mSum      = 0;
         mDelay    = 0;
         mOutValid = 1'b0;
         mOutData  = '0;
         modelLive = 1'b1;
      end else if (mOutValid) begin
         if (outReady) begin
            mOutValid = 1'b0;
            mSum      = 0;
         end
      end else if (mDelay == 2) begin
         mBias  = sx(bias);
         mDelay = 1;
      end else if (mDelay == 1) begin
         mOutData  = neuronResult(mSum, mBias);
         mOutValid = 1'b1;
         mDelay    = 0;
      end else if (inValid) begin
         mSum = mSum + sx(inData) * sx(wmem[mCount]);
         mCount++;
         if (mCount == NW) begin
            mCount = 0;
            mDelay = 2;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk);
         modelStep();
      end
   end

   // Every-cycle compare of all outputs against the model, away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (modelLive) begin
            expAccept = (mDelay == 0) && !mOutValid;
            cmp("inReady", inReady, expAccept);
            cmp("weightReadEn", weightReadEn, expAccept);
            if (expAccept) cmp("weightAddr", weightAddr, mCount);
            cmp("outValid", outValid, mOutValid);
            cmp("outData", outData, mOutData);
            cmp("busy", busy, !(expAccept && mCount == 0 && mSum == 0));
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input int nAccepts, input bit gaps);
      int guard;
      for (int i = 0; i < nAccepts; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               inValid  = 1'b0;
               inData   = DW'($urandom);
               outReady = 1'($urandom);
               stepCycle();
            end
         end
         guard = 0;
         while (!inReady && guard < 20) begin
            inValid = 1'b0;
            stepCycle();
            guard++;
         end
         if (!inReady) cmp("inReadyTimeout", 0, 1);
         inValid  = 1'b1;
         inData   = xs[i];
         outReady = 1'($urandom);
         stepCycle();
      end
      inValid  = 1'b0;
      outReady = 1'b0;
   endtask

   task automatic checkOutput(input bit useLit, input logic [DW-1:0] expData,
                              input int expLat, input int hold, input string name);
      int lat;
      lat = 0;
      while (!outValid && lat < 20) begin
         stepCycle();
         lat++;
      end
      cmp({name, "_valid"}, outValid, 1);
      if (useLit) cmp({name, "_data"}, outData, expData);
      if (expLat >= 0) cmp({name, "_latency"}, lat, expLat);
      repeat (hold) begin
         inValid = 1'b1;
         inData  = 16'h7FFF;
         stepCycle();
      end
      if (hold > 0) begin
         cmp({name, "_heldInReady"}, inReady, 0);
         if (useLit) cmp({name, "_heldData"}, outData, expData);
      end
      inValid  = 1'b0;
      outReady = 1'b1;
      stepCycle();
      outReady = 1'b0;
      cmp({name, "_cleared"}, outValid, 0);
      cmp({name, "_readyAfter"}, inReady, 1);
   endtask

   task automatic loadPattern(input logic [DW-1:0] w, input logic [DW-1:0] x0,
                              input logic [DW-1:0] x1, input logic [DW-1:0] x2,
                              input logic [DW-1:0] x3);
      for (int i = 0; i < NW; i++) wmem[i] = w;
      xs[0] = x0; xs[1] = x1; xs[2] = x2; xs[3] = x3;
   endtask

   initial begin
      reset    = 1'b1;
      inValid  = 1'b0;
      inData   = '0;
      outReady = 1'b0;
      bias     = '0;
      loadPattern(16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
      repeat (3) stepCycle();
      cmp("reset_outValid", outValid, 0);
      cmp("reset_outData", outData, 0);
      cmp("reset_busy", busy, 0);
      cmp("reset_weightAddr", weightAddr, 0);
      reset = 1'b0;

      $display("[TB] basic accumulate");
      applyStimulus(NW, 1'b0);
      checkOutput(1'b1, 16'h0A00, 2, 0, "t1");

      $display("[TB] bias handling and ReLU");
      bias = 16'hFE00;
      applyStimulus(NW, 1'b0);
      checkOutput(1'b1, 16'h0800, 2, 0, "t2pos");
      bias = 16'hF000;
      applyStimulus(NW, 1'b0);
      checkOutput(1'b1, 16'h0000, 2, 0, "t2relu");

      $display("[TB] saturation");
      bias = '0;
      loadPattern(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
      applyStimulus(NW, 1'b0);
      checkOutput(1'b1, 16'h7FFF, 2, 0, "t3sat");

      $display("[TB] stalls and output hold");
      loadPattern(16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
      applyStimulus(NW, 1'b1);
      checkOutput(1'b1, 16'h0A00, -1, 5, "t4hold");

      $display("[TB] abort by reset");
      loadPattern(16'h0100, 16'h7000, 16'h7000, 16'h0300, 16'h0400);
      applyStimulus(2, 1'b0);
      reset = 1'b1;
      stepCycle();
      cmp("t5_outValid", outValid, 0);
      cmp("t5_weightAddr", weightAddr, 0);
      cmp("t5_busy", busy, 0);
      reset = 1'b0;
      loadPattern(16'h0100, 16'h0100, 16'h0200, 16'h0300, 16'h0400);
      applyStimulus(NW, 1'b0);
      checkOutput(1'b1, 16'h0A00, 2, 0, "t5fresh");

      $display("[TB] negative mix");
      bias = 16'h0A00;
      loadPattern(16'h0200, 16'hFF00, 16'hFF00, 16'hFF00, 16'hFF00);
      applyStimulus(NW, 1'b0);
      checkOutput(1'b1, 16'h0200, 2, 0, "t6neg");

      $display("[TB] randomised evaluations");
      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < NW; i++) begin
            wmem[i] = DW'($urandom);
            xs[i]   = DW'($urandom);
         end
         bias = DW'($urandom);
         applyStimulus(NW, 1'b1);
         checkOutput(1'b0, '0, -1, $urandom_range(0, 3), "rand");
      end

      repeat (2) stepCycle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
